// File: rtl/pixel_unpacker.sv
// Assembles three consecutive FIFO bytes into one {R,G,B} pixel and presents it
// on a valid/ready interface tagged with start-of-frame, end-of-line and end-of-frame.
module pixel_unpacker #(
    parameter int B    = 8,
    parameter int HPIX = 640,
    parameter int VPIX = 480
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           empty,
    input  logic [B-1:0]   r_data,
    output logic           rd,
    input  logic           clear,
    output logic [3*B-1:0] pix_data,
    output logic           pix_valid,
    input  logic           pix_ready,
    output logic           sof,
    output logic           eol,
    output logic           eof
);

    localparam int CW = (HPIX > 1) ? $clog2(HPIX) : 1;
    localparam int RW = (VPIX > 1) ? $clog2(VPIX) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(HPIX - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(VPIX - 1);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t         state_r;
    state_t         state_nxt_s;
    logic [1:0]     idx_r;
    logic [1:0]     idx_nxt_s;
    logic [3*B-1:0] pix_data_r;
    logic [3*B-1:0] pix_data_nxt_s;
    logic           pix_valid_r;
    logic           pix_valid_nxt_s;
    logic [CW-1:0]  col_r;
    logic [CW-1:0]  col_nxt_s;
    logic [RW-1:0]  row_r;
    logic [RW-1:0]  row_nxt_s;
    logic           sof_r;
    logic           eol_r;
    logic           eof_r;
    logic           sof_nxt_s;
    logic           eol_nxt_s;
    logic           eof_nxt_s;
    logic           pop_s;
    logic           accept_s;

    // The pop strobe is combinational so the FIFO head advances on the capturing edge.
    assign pop_s    = (state_r == COLLECT) & ~empty & ~clear & reset;
    assign accept_s = pix_valid_r & pix_ready;

    assign rd        = pop_s;
    assign pix_data  = pix_data_r;
    assign pix_valid = pix_valid_r;
    assign sof       = sof_r;
    assign eol       = eol_r;
    assign eof       = eof_r;

    // Next-state, byte capture and frame-position logic.
    always_comb begin
        state_nxt_s     = state_r;
        idx_nxt_s       = idx_r;
        pix_data_nxt_s  = pix_data_r;
        pix_valid_nxt_s = pix_valid_r;
        col_nxt_s       = col_r;
        row_nxt_s       = row_r;

        if (clear) begin
            // Partial pixel bytes stay in pix_data; they are ignored while pix_valid is low.
            state_nxt_s     = COLLECT;
            idx_nxt_s       = 2'd0;
            pix_valid_nxt_s = 1'b0;
            col_nxt_s       = {CW{1'b0}};
            row_nxt_s       = {RW{1'b0}};
        end else if (state_r == HOLD) begin
            if (accept_s) begin
                state_nxt_s     = COLLECT;
                pix_valid_nxt_s = 1'b0;
                if (col_r == COL_LAST) begin
                    col_nxt_s = {CW{1'b0}};
                    if (row_r == ROW_LAST) begin
                        row_nxt_s = {RW{1'b0}};
                    end else begin
                        row_nxt_s = row_r + RW'(1);
                    end
                end else begin
                    col_nxt_s = col_r + CW'(1);
                end
            end else begin
                state_nxt_s = HOLD;
            end
        end else begin
            if (pop_s) begin
                case (idx_r)
                    2'd0:    pix_data_nxt_s[3*B-1:2*B] = r_data;
                    2'd1:    pix_data_nxt_s[2*B-1:B]   = r_data;
                    2'd2:    pix_data_nxt_s[B-1:0]     = r_data;
                    default: pix_data_nxt_s            = pix_data_r;
                endcase
                if (idx_r == 2'd2) begin
                    idx_nxt_s       = 2'd0;
                    state_nxt_s     = HOLD;
                    pix_valid_nxt_s = 1'b1;
                end else begin
                    idx_nxt_s = idx_r + 2'd1;
                end
            end else begin
                state_nxt_s = COLLECT;
            end
        end

        sof_nxt_s = pix_valid_nxt_s & (col_nxt_s == {CW{1'b0}}) & (row_nxt_s == {RW{1'b0}});
        eol_nxt_s = pix_valid_nxt_s & (col_nxt_s == COL_LAST);
        eof_nxt_s = pix_valid_nxt_s & (col_nxt_s == COL_LAST) & (row_nxt_s == ROW_LAST);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= COLLECT;
            idx_r       <= 2'd0;
            pix_data_r  <= {(3*B){1'b0}};
            pix_valid_r <= 1'b0;
            col_r       <= {CW{1'b0}};
            row_r       <= {RW{1'b0}};
            sof_r       <= 1'b0;
            eol_r       <= 1'b0;
            eof_r       <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            idx_r       <= idx_nxt_s;
            pix_data_r  <= pix_data_nxt_s;
            pix_valid_r <= pix_valid_nxt_s;
            col_r       <= col_nxt_s;
            row_r       <= row_nxt_s;
            sof_r       <= sof_nxt_s;
            eol_r       <= eol_nxt_s;
            eof_r       <= eof_nxt_s;
        end
    end

endmodule
